// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable bit period, width and parity, feeding a small
// first-word-fall-through FIFO read through a 16-bit word (bit 15 set = empty).
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        RX,
  input  logic        rd,
  output logic [15:0] out,
  output logic        overrun,
  output logic        busy
);
  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTF_W = PTR_W + 1;
  localparam int unsigned WORD_W = 10;
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic [CNTF_W-1:0] CNT_FULL  = CNTF_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t            state, state_nx;
  logic              rx_m, rx_s, rx_p;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        data;
  logic              perr;
  logic              cnt_rst, idle_rst, data_smp, par_smp, push;
  logic [WORD_W-1:0] push_word;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNTF_W-1:0] count;
  logic              fifo_empty, fifo_full, do_pop, do_push;

  // Two-flop synchroniser plus previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (clear) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (rx_p && !rx_s) state_nx = S_START;
      S_START:  if (cnt == HALF_LAST) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (cnt == BIT_LAST && bit_idx == IDX_LAST)
                  state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (cnt == BIT_LAST) state_nx = S_STOP;
      S_STOP:   if (cnt == BIT_LAST) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_rst  = 1'b0;
    idle_rst = 1'b0;
    data_smp = 1'b0;
    par_smp  = 1'b0;
    push     = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_rst  = 1'b1;
        idle_rst = 1'b1;
      end
      S_START:  cnt_rst = (cnt == HALF_LAST);
      S_DATA: begin
        cnt_rst  = (cnt == BIT_LAST);
        data_smp = (cnt == BIT_LAST);
      end
      S_PARITY: begin
        cnt_rst = (cnt == BIT_LAST);
        par_smp = (cnt == BIT_LAST);
      end
      S_STOP: begin
        cnt_rst = (cnt == BIT_LAST);
        push    = (cnt == BIT_LAST);
      end
      default: cnt_rst = 1'b1;
    endcase
  end

  // Bit timing and frame assembly; data is zeroed while idle so unused bits read 0
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
      perr    <= 1'b0;
    end else begin
      cnt <= cnt_rst ? '0 : cnt + CNT_W'(1);
      if (idle_rst) begin
        bit_idx <= '0;
        data    <= '0;
        perr    <= 1'b0;
      end
      if (data_smp) begin
        data[bit_idx] <= rx_s;
        bit_idx       <= bit_idx + 3'd1;
      end
      if (par_smp) perr <= (PARITY == 1) ? ~(^data ^ rx_s) : (^data ^ rx_s);
    end
  end

  assign push_word  = {perr, ~rx_s, data};
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign do_pop     = rd && !fifo_empty;
  assign do_push    = push && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_word;
  end

  // A full FIFO drops the incoming word unless a pop frees a slot in the same cycle
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNTF_W'(1);
        2'b01:   count <= count - CNTF_W'(1);
        default: count <= count;
      endcase
      if (push && fifo_full && !do_pop) overrun <= 1'b1;
    end
  end

  assign out  = fifo_empty ? 16'h8000 : {6'b0, mem[rd_ptr]};
  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames and rd strobes drive a queue-based model
// whose predicted head word, overrun and busy are compared every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int CLKS       = 25;
  localparam int DEPTH      = 4;
  localparam int FRAME_BITS = 11;
  // Line change to visible push: 2 sync flops + edge register, half-bit start
  // sample, then ten full bit periods.
  localparam int PUSH_OFS   = 3 + CLKS / 2 + (FRAME_BITS - 1) * CLKS;

  typedef struct {int e; logic [9:0] w;} push_t;
  typedef struct {int from; int upto;} span_t;

  logic        clk = 1'b0;
  logic        clear, RX, rd;
  logic [15:0] out;
  logic        overrun, busy;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          cmp_en = 1'b0;
  bit          noise_on = 1'b0;
  logic [9:0]  mq[$];
  bit          m_ovr = 1'b0;
  push_t       sched[$];
  span_t       spans[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .clear(clear), .RX(RX), .rd(rd),
    .out(out), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_out();
    if (mq.size() == 0) return 16'h8000;
    return {6'b0, mq[0]};
  endfunction

  function automatic bit exp_busy();
    return spans.size() > 0 && spans[0].from <= cyc;
  endfunction

  // Reference model: frame arrivals at precomputed edges feed a bounded queue
  always @(posedge clk) begin
    bit pop, full, have;
    logic [9:0] w;
    cyc = cyc + 1;
    if (clear) begin
      mq.delete();
      sched.delete();
      spans.delete();
      m_ovr = 1'b0;
    end else begin
      have = 1'b0;
      w = '0;
      while (sched.size() > 0 && sched[0].e <= cyc) begin
        if (sched[0].e == cyc) begin
          have = 1'b1;
          w = sched[0].w;
        end
        void'(sched.pop_front());
      end
      full = (mq.size() == DEPTH);
      pop  = rd && mq.size() > 0;
      if (pop) void'(mq.pop_front());
      if (have) begin
        if (full && !pop) m_ovr = 1'b1;
        else mq.push_back(w);
      end
      while (spans.size() > 0 && spans[0].upto <= cyc) void'(spans.pop_front());
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out", out, exp_out());
      chk("overrun", 16'(overrun), 16'(m_ovr));
      chk("busy", 16'(busy), 16'(exp_busy()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Even parity: perr when data XOR parity bit is 1; ferr when stop bit is low
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    sched.push_back('{cyc + PUSH_OFS, {(^d) ^ p, ~s, d}});
    spans.push_back('{cyc + 3, cyc + PUSH_OFS});
    for (int i = 0; i < FRAME_BITS; i++) begin
      RX = bits[i];
      tick(CLKS);
    end
  endtask

  task automatic glitch(input int len);
    spans.push_back('{cyc + 3, cyc + 3 + CLKS / 2});
    RX = 1'b0;
    tick(len);
    RX = 1'b1;
    tick(CLKS);
  endtask

  task automatic pop_expect(input logic [15:0] exp);
    chk("pop_head", out, exp);
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic pop_any();
    rd = 1'b1;
    tick(1);
    rd = 1'b0;
  endtask

  task automatic rd_noise();
    while (noise_on) begin
      rd = ($urandom_range(0, 2) == 0);
      tick(1);
    end
    rd = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic p, s;
    int pe;
    clear = 1'b1;
    RX = 1'b1;
    rd = 1'b0;
    tick(3);
    clear = 1'b0;
    chk("reset_out", out, 16'h8000);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_overrun", 16'(overrun), 16'h0);
    cmp_en = 1'b1;
    tick(5);

    send_frame(8'h55, 1'b0, 1'b1);
    tick(2);
    chk("lit_55", out, 16'h0055);
    pop_expect(16'h0055);
    chk("lit_empty", out, 16'h8000);

    send_frame(8'hA3, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b1);
    tick(2);
    pop_expect(16'h00A3);
    pop_expect(16'h0001);
    pop_expect(16'h007E);
    chk("lit_drained", out, 16'h8000);

    send_frame(8'h03, 1'b1, 1'b1);
    tick(2);
    pop_expect(16'h0203);
    send_frame(8'h03, 1'b0, 1'b1);
    tick(2);
    pop_expect(16'h0003);

    // Low stop bit, then the line stays low: must not start another frame
    send_frame(8'h41, 1'b0, 1'b0);
    tick(3 * CLKS);
    chk("lit_ferr", out, 16'h0141);
    chk("lit_break_idle", 16'(busy), 16'h0);
    RX = 1'b1;
    tick(4);
    pop_expect(16'h0141);

    glitch(CLKS / 4);
    chk("lit_glitch_out", out, 16'h8000);
    chk("lit_glitch_busy", 16'(busy), 16'h0);

    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h10 + i);
      send_frame(d, ^d, 1'b1);
    end
    tick(2);
    chk("lit_overrun", 16'(overrun), 16'h1);
    pop_expect(16'h0010);
    pop_expect(16'h0011);

    // Clear in the middle of a frame while entries and overrun are pending
    sched.push_back('{cyc + PUSH_OFS, 10'h0FF});
    spans.push_back('{cyc + 3, cyc + PUSH_OFS});
    RX = 1'b0;
    tick(CLKS);
    RX = 1'b1;
    tick(2 * CLKS + CLKS / 2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    chk("lit_clear_out", out, 16'h8000);
    chk("lit_clear_busy", 16'(busy), 16'h0);
    chk("lit_clear_overrun", 16'(overrun), 16'h0);
    tick(5);

    // Full FIFO with a pop on the very cycle of the fifth push
    for (int i = 0; i < 4; i++) begin
      d = 8'(8'h20 + i);
      send_frame(d, ^d, 1'b1);
    end
    pe = cyc + PUSH_OFS;
    fork
      send_frame(8'h24, 1'b0, 1'b1);
      begin
        wait (cyc == pe - 1);
        #1 rd = 1'b1;
        wait (cyc == pe);
        #1 rd = 1'b0;
      end
    join
    tick(2);
    chk("lit_no_overrun", 16'(overrun), 16'h0);
    chk("lit_head_after", out, 16'h0021);
    repeat (DEPTH) pop_any();
    tick(2);

    noise_on = 1'b1;
    fork
      rd_noise();
      begin
        for (int n = 0; n < 40; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            glitch($urandom_range(1, CLKS / 2 - 1));
          end else begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : ^d;
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s);
            if (!s) begin
              tick($urandom_range(1, 2 * CLKS));
              RX = 1'b1;
              tick(2);
            end else begin
              tick($urandom_range(0, 4));
            end
          end
        end
        noise_on = 1'b0;
      end
    join
    tick(2);
    repeat (DEPTH + 1) pop_any();
    tick(2);
    chk("lit_final_empty", out, 16'h8000);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
